uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter (8N1 serializer with a valid/ready byte input) among N byte-stream requesters.
- Arbitration is round-robin at packet granularity.
- A grant is held until the requester's last byte is accepted or a burst limit is reached.
- A programmable idle gap is inserted between packets.
- Sits between the echo/command sources and the shared tx serializer that drives io_tx.

---
 rtl/uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 559 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one byte-wide UART transmitter (8N1 serializer with a valid/ready input) among N
// byte-stream requesters. Arbitration is round-robin at packet granularity. A grant is held
// until the owner's last byte is accepted or MAX_BYTES bytes have been accepted. After each
// release, the arbiter waits GAP_CYCLES idle cycles before it arbitrates again.
//
// Parameters:
//   N           number of requester ports (2..8)
//   MAX_BYTES   bytes per grant before a forced release (1..255)
//   GAP_CYCLES  idle cycles after each released grant (0..65535)
//
// Ports:
//   clock         system clock; all logic uses the rising edge
//   reset         synchronous, active-low
//   io_in_valid   per-requester byte valid
//   io_in_bits    byte of requester i at [8i+7:8i]
//   io_in_last    per-requester last-byte-of-packet flag
//   io_in_ready   per-requester accept; only the owner can see ready
//   io_out_valid  byte to serializer valid
//   io_out_bits   byte to serializer; zero when io_out_valid is low
//   io_out_ready  serializer accepts byte
//   io_grant      one-hot current owner; zero when there is no owner
//   io_busy       high while a grant or an idle gap is in progress

module uart_tx_arbiter #(
  parameter int unsigned N          = 2,
  parameter int unsigned MAX_BYTES  = 16,
  parameter int unsigned GAP_CYCLES = 40
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  input  logic [8*N-1:0] io_in_bits,
  input  logic [N-1:0]   io_in_last,
  output logic [N-1:0]   io_in_ready,
  output logic           io_out_valid,
  output logic [7:0]     io_out_bits,
  input  logic           io_out_ready,
  output logic [N-1:0]   io_grant,
  output logic           io_busy
);

  localparam int unsigned     PtrW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(N - 1);
  // Release fires on the transfer that brings the count to MAX_BYTES.
  localparam logic [7:0]      ByteLast = 8'(MAX_BYTES - 1);
  localparam logic [15:0]     GapLast  = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  // Holds the last winner; while granting it is also the owner's index.
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [7:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]     gap_cnt_q, gap_cnt_d;

  // Round-robin search
  logic            arb_found;
  logic [PtrW-1:0] arb_idx;
  logic [PtrW-1:0] cand;
  logic [N-1:0]    arb_onehot;

  // Owner's request lines
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_bits;

  logic            xfer;
  logic            rel;

  // Scan from ptr+1 upward with an explicit wrap at N-1, so non-power-of-two N never
  // lands on an index that has no port.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (cand == PtrLast) ? '0 : cand + 1'b1;
      if (!arb_found && io_in_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    arb_onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      arb_onehot[i] = (arb_idx == PtrW'(i));
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_bits  = 8'h00;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr_q == PtrW'(i)) begin
        sel_valid = io_in_valid[i];
        sel_last  = io_in_last[i];
        sel_bits  = io_in_bits[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    io_out_valid = 1'b0;
    io_out_bits  = 8'h00;
    io_in_ready  = '0;
    xfer         = 1'b0;
    rel          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d    = StGrant;
          grant_d    = arb_onehot;
          ptr_d      = arb_idx;
          byte_cnt_d = 8'd0;
        end
      end

      StGrant: begin
        // Combinational pass-through from the owner to the serializer.
        io_out_valid = sel_valid;
        io_out_bits  = sel_valid ? sel_bits : 8'h00;
        io_in_ready  = grant_q & {N{io_out_ready}};
        xfer         = sel_valid & io_out_ready;
        rel          = xfer & (sel_last | (byte_cnt_q == ByteLast));
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
        end
        if (rel) begin
          grant_d   = '0;
          gap_cnt_d = 16'd0;
          state_d   = (GAP_CYCLES == 0) ? StIdle : StGap;
        end
      end

      StGap: begin
        gap_cnt_d = gap_cnt_q + 16'd1;
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      ptr_q      <= PtrLast;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign io_grant = grant_q;
  assign io_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N=3, MAX_BYTES=4, GAP_CYCLES=40).
// Requesters are byte queues served by a background driver; a monitor logs every
// serializer transfer. A packet-level reference model predicts transfer order and spacing.

module tb_uart_tx_arbiter;

  localparam int N    = 3;
  localparam int MAXB = 4;
  localparam int GAP  = 40;
  localparam logic [N-1:0] G0 = 3'b001;

  logic           clock;
  logic           reset;
  logic [N-1:0]   io_in_valid;
  logic [8*N-1:0] io_in_bits;
  logic [N-1:0]   io_in_last;
  logic [N-1:0]   io_in_ready;
  logic           io_out_valid;
  logic [7:0]     io_out_bits;
  logic           io_out_ready;
  logic [N-1:0]   io_grant;
  logic           io_busy;

  uart_tx_arbiter #(
    .N          (N),
    .MAX_BYTES  (MAXB),
    .GAP_CYCLES (GAP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_bits   (io_in_bits),
    .io_in_last   (io_in_last),
    .io_in_ready  (io_in_ready),
    .io_out_valid (io_out_valid),
    .io_out_bits  (io_out_bits),
    .io_out_ready (io_out_ready),
    .io_grant     (io_grant),
    .io_busy      (io_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    int         port;
    logic [7:0] data;
    logic       ok;
  } xfer_t;

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         first;
  } exp_t;

  xfer_t        log_q [$];
  exp_t         exp_q [$];
  logic [8:0]   rq [N][$];          // {last, byte} per requester
  logic [N-1:0] mute = '0;
  int           ready_mode = 0;     // 0: ready high, 1: random, 2: ready low
  int           cyc;
  int           checks;
  int           errors;
  int           mptr;               // model's round-robin pointer
  logic         busy_hist  [int];
  logic [N-1:0] grant_hist [int];
  logic [N-1:0] ready_hist [int];

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !mute[i]) begin
        io_in_valid[i]       = 1'b1;
        io_in_bits[8*i +: 8] = rq[i][0][7:0];
        io_in_last[i]        = rq[i][0][8];
      end else begin
        io_in_valid[i]       = 1'b0;
        io_in_bits[8*i +: 8] = 8'h00;
        io_in_last[i]        = 1'b0;
      end
    end
    case (ready_mode)
      0:       io_out_ready = 1'b1;
      1:       io_out_ready = ($urandom_range(0, 3) != 0);
      default: io_out_ready = 1'b0;
    endcase
  endtask

  // Requesters + monitor: sample at negedge, update inputs 1 time unit after posedge.
  initial begin : drive_mon
    logic [N-1:0] acc;
    int           p;
    logic         ok;
    cyc = 0;
    drive_inputs();
    forever begin
      @(negedge clock);
      busy_hist[cyc]  = io_busy;
      grant_hist[cyc] = io_grant;
      ready_hist[cyc] = io_in_ready;
      acc = io_in_valid & io_in_ready;
      if (io_out_valid && io_out_ready) begin
        p = -1;
        for (int i = 0; i < N; i++) if (io_grant[i]) p = i;
        ok = ($countones(io_grant) == 1) && (io_in_ready == io_grant) && io_busy;
        log_q.push_back('{cyc: cyc, port: p, data: io_out_bits, ok: ok});
      end
      @(posedge clock);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      drive_inputs();
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1);
  end

  // Packet-level model: round-robin over ports with pending bytes, each grant taking bytes
  // up to the packet's last or MAXB bytes, whichever comes first.
  task automatic build_expected();
    logic [8:0] mq [N][$];
    logic [8:0] b;
    int         found;
    int         cnt;
    bit         done;
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    exp_q.delete();
    forever begin
      found = -1;
      for (int k = 1; k <= N; k++) begin
        if (found < 0 && mq[(mptr + k) % N].size() > 0) found = (mptr + k) % N;
      end
      if (found < 0) break;
      cnt  = 0;
      done = 0;
      while (!done) begin
        b = mq[found].pop_front();
        exp_q.push_back('{port: found, data: b[7:0], first: (cnt == 0)});
        cnt++;
        done = b[8] || (cnt == MAXB) || (mq[found].size() == 0);
      end
      mptr = found;
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < N; i++) rq[i].delete();
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_queues();
    mute       = '0;
    ready_mode = 0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    mptr  = N - 1;
    log_q.delete();
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    bit empty;
    n = 0;
    forever begin
      @(negedge clock);
      empty = 1;
      for (int i = 0; i < N; i++) if (rq[i].size() != 0) empty = 0;
      if (empty && !io_busy) break;
      n++;
      if (n > budget) break;
    end
    checks++;
    if (n > budget) begin
      errors++;
      $display("FAIL %s_done: got still busy after %0d cycles, expected idle", name, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_queues();
    rq[1].push_back({1'b1, 8'h77});
    repeat (3) @(negedge clock);
    checks++;
    if (io_grant !== '0) begin
      errors++;
      $display("FAIL reset_grant: got %b, expected 000", io_grant);
    end
    checks++;
    if (io_out_valid !== 1'b0 || io_out_bits !== 8'h00) begin
      errors++;
      $display("FAIL reset_out: got valid %b bits %h, expected 0/00", io_out_valid, io_out_bits);
    end
    checks++;
    if (io_in_ready !== '0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_busy: got ready %b busy %b, expected 000/0",
               io_in_ready, io_busy);
    end
  endtask

  task automatic test_single();
    int start;
    int t;
    int bad;
    apply_reset();
    start = cyc;
    rq[0].push_back({1'b1, 8'h55});
    build_expected();
    wait_done(300, "single");
    checks++;
    if (log_q.size() !== 1) begin
      errors++;
      $display("FAIL single_count: got %0d transfers, expected 1", log_q.size());
    end else begin
      t = log_q[0].cyc;
      checks++;
      if (log_q[0].port !== 0 || log_q[0].data !== 8'h55 || log_q[0].ok !== 1'b1) begin
        errors++;
        $display("FAIL single_xfer: got port %0d byte %h ok %b, expected 0/55/1",
                 log_q[0].port, log_q[0].data, log_q[0].ok);
      end
      checks++;
      if (t !== start + 2 || grant_hist[start + 1] !== '0 || grant_hist[start + 2] !== G0) begin
        errors++;
        $display("FAIL single_latency: got xfer cycle %0d grant %b->%b, expected %0d 000->001",
                 t - start, grant_hist[start + 1], grant_hist[start + 2], 2);
      end
      bad = 0;
      for (int k = 1; k <= GAP; k++) begin
        if (busy_hist[t + k] !== 1'b1 || grant_hist[t + k] !== '0) bad++;
      end
      checks++;
      if (bad !== 0 || busy_hist[t + GAP + 1] !== 1'b0) begin
        errors++;
        $display("FAIL single_gap: got %0d bad gap cycles, busy after gap %b, expected 0/0",
                 bad, busy_hist[t + GAP + 1]);
      end
    end
  endtask

  task automatic test_two_ports();
    int start;
    int bad;
    int dt;
    apply_reset();
    start = cyc;
    rq[0].push_back({1'b0, 8'h41});
    rq[0].push_back({1'b1, 8'h42});
    rq[1].push_back({1'b1, 8'h4B});
    build_expected();
    wait_done(400, "two");
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL two_count: got %0d transfers, expected %0d", log_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      checks++;
      if (log_q[j].port !== exp_q[j].port || log_q[j].data !== exp_q[j].data ||
          log_q[j].ok !== 1'b1) begin
        errors++;
        $display("FAIL two_xfer[%0d]: got port %0d byte %h, expected port %0d byte %h",
                 j, log_q[j].port, log_q[j].data, exp_q[j].port, exp_q[j].data);
      end
      if (j > 0) begin
        dt = exp_q[j].first ? GAP + 2 : 1;
        checks++;
        if (log_q[j].cyc - log_q[j-1].cyc !== dt) begin
          errors++;
          $display("FAIL two_spacing[%0d]: got %0d cycles, expected %0d",
                   j, log_q[j].cyc - log_q[j-1].cyc, dt);
        end
      end
    end
    if (log_q.size() >= 2) begin
      bad = 0;
      for (int c = start + 1; c <= log_q[1].cyc; c++) if (ready_hist[c][1] !== 1'b0) bad++;
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL two_ready1: got ready[1] high on %0d cycles, expected 0", bad);
      end
    end
  endtask

  task automatic test_round_robin();
    int dt;
    apply_reset();
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < N; i++) rq[i].push_back({1'b1, 8'(8'h10 * i + j)});
    end
    build_expected();
    wait_done(600, "rr");
    checks++;
    if (log_q.size() !== 2 * N) begin
      errors++;
      $display("FAIL rr_count: got %0d transfers, expected %0d", log_q.size(), 2 * N);
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      checks++;
      if (log_q[j].port !== j % N || log_q[j].data !== exp_q[j].data ||
          log_q[j].ok !== 1'b1) begin
        errors++;
        $display("FAIL rr_order[%0d]: got port %0d byte %h, expected port %0d byte %h",
                 j, log_q[j].port, log_q[j].data, j % N, exp_q[j].data);
      end
      if (j > 0) begin
        dt = GAP + 2;
        checks++;
        if (log_q[j].cyc - log_q[j-1].cyc !== dt) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles, expected %0d",
                   j, log_q[j].cyc - log_q[j-1].cyc, dt);
        end
      end
    end
  endtask

  task automatic test_max_bytes();
    int ports [7];
    int dt;
    ports = '{0, 0, 0, 0, 1, 0, 0};
    apply_reset();
    for (int b = 1; b <= 6; b++) rq[0].push_back({(b == 6), 8'(b)});
    rq[1].push_back({1'b1, 8'h4B});
    build_expected();
    wait_done(600, "maxb");
    checks++;
    if (log_q.size() !== 7) begin
      errors++;
      $display("FAIL maxb_count: got %0d transfers, expected 7", log_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      checks++;
      if (log_q[j].port !== ports[j] || log_q[j].data !== exp_q[j].data ||
          log_q[j].ok !== 1'b1) begin
        errors++;
        $display("FAIL maxb_xfer[%0d]: got port %0d byte %h, expected port %0d byte %h",
                 j, log_q[j].port, log_q[j].data, ports[j], exp_q[j].data);
      end
      if (j > 0) begin
        dt = exp_q[j].first ? GAP + 2 : 1;
        checks++;
        if (log_q[j].cyc - log_q[j-1].cyc !== dt) begin
          errors++;
          $display("FAIL maxb_spacing[%0d]: got %0d cycles, expected %0d",
                   j, log_q[j].cyc - log_q[j-1].cyc, dt);
        end
      end
    end
  endtask

  task automatic test_stall();
    int bad;
    apply_reset();
    ready_mode = 2;
    rq[0].push_back({1'b0, 8'h31});
    rq[0].push_back({1'b0, 8'h32});
    rq[0].push_back({1'b1, 8'h33});
    rq[2].push_back({1'b1, 8'h99});
    build_expected();
    repeat (3) @(negedge clock);
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (io_out_valid !== 1'b1 || io_out_bits !== 8'h31 || io_grant !== G0 ||
          io_in_ready !== '0) bad++;
    end
    checks++;
    if (bad !== 0 || log_q.size() !== 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d unstable cycles, %0d transfers, expected 0/0",
               bad, log_q.size());
    end
    ready_mode = 0;
    wait_done(400, "stall");
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d transfers, expected %0d", log_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      checks++;
      if (log_q[j].port !== exp_q[j].port || log_q[j].data !== exp_q[j].data ||
          log_q[j].ok !== 1'b1) begin
        errors++;
        $display("FAIL stall_xfer[%0d]: got port %0d byte %h, expected port %0d byte %h",
                 j, log_q[j].port, log_q[j].data, exp_q[j].port, exp_q[j].data);
      end
    end
  endtask

  task automatic test_hold_valid();
    int n;
    apply_reset();
    rq[0].push_back({1'b0, 8'hA0});
    rq[0].push_back({1'b1, 8'hA1});
    rq[1].push_back({1'b1, 8'hB0});
    build_expected();
    n = 0;
    while (log_q.size() < 1 && n < 50) begin
      @(negedge clock);
      #2;
      n++;
    end
    mute[0] = 1'b1;
    repeat (20) @(negedge clock);
    checks++;
    if (io_grant !== G0 || log_q.size() !== 1 || io_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_grant: got grant %b, %0d transfers, valid %b, expected 001/1/0",
               io_grant, log_q.size(), io_out_valid);
    end
    mute[0] = 1'b0;
    wait_done(400, "hold");
    checks++;
    if (log_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL hold_count: got %0d transfers, expected %0d", log_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
      checks++;
      if (log_q[j].port !== exp_q[j].port || log_q[j].data !== exp_q[j].data) begin
        errors++;
        $display("FAIL hold_xfer[%0d]: got port %0d byte %h, expected port %0d byte %h",
                 j, log_q[j].port, log_q[j].data, exp_q[j].port, exp_q[j].data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int start;
    apply_reset();
    for (int b = 0; b < 5; b++) rq[1].push_back({(b == 4), 8'(8'hC0 + b)});
    n = 0;
    while (log_q.size() < 2 && n < 50) begin
      @(negedge clock);
      #2;
      n++;
    end
    checks++;
    if (log_q.size() < 2) begin
      errors++;
      $display("FAIL rmid_start: got %0d transfers, expected 2", log_q.size());
    end
    reset = 1'b0;
    clear_queues();
    @(negedge clock);
    checks++;
    if (io_grant !== '0 || io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_in_ready !== '0) begin
      errors++;
      $display("FAIL rmid_drop: got grant %b valid %b busy %b ready %b, expected all 0",
               io_grant, io_out_valid, io_busy, io_in_ready);
    end
    reset = 1'b1;
    mptr  = N - 1;
    log_q.delete();
    start = cyc;
    rq[0].push_back({1'b1, 8'hE0});
    rq[2].push_back({1'b1, 8'hE2});
    build_expected();
    wait_done(300, "rmid");
    checks++;
    if (log_q.size() !== 2) begin
      errors++;
      $display("FAIL rmid_count: got %0d transfers, expected 2", log_q.size());
    end else begin
      checks++;
      if (log_q[0].port !== 0 || log_q[0].cyc !== start + 2 || log_q[1].port !== 2 ||
          log_q[0].data !== exp_q[0].data || log_q[1].data !== exp_q[1].data) begin
        errors++;
        $display("FAIL rmid_order: got ports %0d,%0d first at +%0d, expected 0,2 at +2",
                 log_q[0].port, log_q[1].port, log_q[0].cyc - start);
      end
    end
  endtask

  task automatic test_random();
    int start;
    int np;
    int len;
    int dt;
    int total;
    for (int r = 0; r < 8; r++) begin
      @(negedge clock);
      log_q.delete();
      ready_mode = $urandom_range(0, 1);
      total = 0;
      for (int i = 0; i < N; i++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
          total++;
        end
      end
      if (total == 0) rq[$urandom_range(0, N - 1)].push_back({1'b1, 8'h5A});
      start = cyc;
      build_expected();
      wait_done(3000, "rand");
      checks++;
      if (log_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d transfers, expected %0d",
                 r, log_q.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
        checks++;
        if (log_q[j].port !== exp_q[j].port || log_q[j].data !== exp_q[j].data ||
            log_q[j].ok !== 1'b1) begin
          errors++;
          $display("FAIL rand%0d_xfer[%0d]: got port %0d byte %h, expected port %0d byte %h",
                   r, j, log_q[j].port, log_q[j].data, exp_q[j].port, exp_q[j].data);
        end
        if (ready_mode == 0) begin
          dt = (j == 0) ? 2 : (exp_q[j].first ? GAP + 2 : 1);
          checks++;
          if (log_q[j].cyc - ((j == 0) ? start : log_q[j-1].cyc) !== dt) begin
            errors++;
            $display("FAIL rand%0d_spacing[%0d]: got %0d cycles, expected %0d", r, j,
                     log_q[j].cyc - ((j == 0) ? start : log_q[j-1].cyc), dt);
          end
        end
      end
    end
    ready_mode = 0;
  endtask

  initial begin : main
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    mptr   = N - 1;
    test_reset();
    test_single();
    test_two_ports();
    test_round_robin();
    test_max_bytes();
    test_stall();
    test_hold_valid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
